// File: rtl/clock_divider_multi.sv
// Multi-channel programmable clock divider. Each channel emits a 50%-duty square
// wave (period 2*D) and a one-cycle tick (period D). Outputs are clock enables, not clocks.
module clock_divider_multi #(
  parameter int unsigned CHANNELS        = 2,
  parameter int unsigned COUNT_W         = 26,
  parameter int unsigned DEFAULT_DIVISOR = 25000000
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic [CHANNELS-1:0]         enable,
  input  logic [CHANNELS-1:0]         load,
  input  logic [CHANNELS*COUNT_W-1:0] divisor,
  output logic [CHANNELS-1:0]         clock_out,
  output logic [CHANNELS-1:0]         tick
);

  localparam logic [COUNT_W-1:0] DEFAULT_D = COUNT_W'(DEFAULT_DIVISOR);

  logic [COUNT_W-1:0]  cnt_q     [CHANNELS];
  logic [COUNT_W-1:0]  cnt_d     [CHANNELS];
  logic [COUNT_W-1:0]  div_q     [CHANNELS];
  logic [COUNT_W-1:0]  div_d     [CHANNELS];
  logic [CHANNELS-1:0] clk_out_q, clk_out_d;
  logic [CHANNELS-1:0] tick_q, tick_d;

  // Terminal count for a divisor; a divisor of 0 behaves exactly like 1.
  function automatic logic [COUNT_W-1:0] last_count(input logic [COUNT_W-1:0] d);
    return (d == '0) ? '0 : d - COUNT_W'(1);
  endfunction

  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      // NOTE: every always_comb output gets a default first, so no path can infer a latch.
      cnt_d[i]     = cnt_q[i];
      div_d[i]     = div_q[i];
      clk_out_d[i] = clk_out_q[i];
      tick_d[i]    = 1'b0;

      if (load[i]) begin
        div_d[i]     = divisor[i*COUNT_W +: COUNT_W];
        cnt_d[i]     = '0;
        clk_out_d[i] = 1'b0;
      end else if (enable[i]) begin
        if (cnt_q[i] == last_count(div_q[i])) begin
          cnt_d[i]     = '0;
          tick_d[i]    = 1'b1;
          clk_out_d[i] = ~clk_out_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + COUNT_W'(1);
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_q[i] <= '0;
        div_q[i] <= DEFAULT_D;
      end
      clk_out_q <= '0;
      tick_q    <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_q[i] <= cnt_d[i];
        div_q[i] <= div_d[i];
      end
      clk_out_q <= clk_out_d;
      tick_q    <= tick_d;
    end
  end

  assign clock_out = clk_out_q;
  assign tick      = tick_q;

endmodule
